// File: rtl/fir_pkg.sv
// Shared widths and default constants for the FIR chain, so fir_filter and
// the decimating output stage agree on sample sizes.
package fir_pkg;

    localparam int FIR_IN_W  = 8;   // fir_filter input sample width
    localparam int FIR_OUT_W = 16;  // fir_filter y width, feeds fir_decim_out

    localparam int DEC_OUT_W = 8;   // decimated output sample width
    localparam int DEC_SHIFT = 4;   // right shift after rounding
    localparam int DEC_DECIM = 4;   // keep one sample in every DEC_DECIM
    localparam int DEC_DEPTH = 4;   // output FIFO depth
    localparam int DROP_W    = 8;   // dropped-sample counter width

    // Width of a counter/pointer covering 0..n-1; never narrower than 1 bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// Sample stream into the output stage (valid only, no backpressure) and the
// valid/ready stream out of it towards the DAC or packetiser.
interface fir_decim_out_if
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_OUT_W,
    parameter int OUT_W = DEC_OUT_W
);
    logic [IN_W-1:0]  in_sample;
    logic             in_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // Environment side: produces samples and consumes the output stream.
    modport master (
        output in_sample, in_valid, out_ready,
        input  out_data, out_valid
    );

    // Output stage side.
    modport slave (
        input  in_sample, in_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous show-ahead FIFO: dout presents the head entry whenever the FIFO
// is not empty. A push while full is accepted only together with a pop.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = DEC_OUT_W,
    parameter int DEPTH = DEC_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    // Empty FIFO shows zero rather than a stale entry.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; pointers alone decide which entries are live.
    // NOTE: the array has no reset -- an emptied FIFO never exposes its
    // contents, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally on AW bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_decim_out.sv
// Output stage behind fir_filter: keeps one sample in DECIM, rounds, shifts
// and saturates it to OUT_W bits, and queues it for a valid/ready consumer.
// Samples that find the queue full are dropped and counted.
module fir_decim_out
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_OUT_W,
    parameter int OUT_W = DEC_OUT_W,
    parameter int SHIFT = DEC_SHIFT,
    parameter int DECIM = DEC_DECIM,
    parameter int DEPTH = DEC_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    fir_decim_out_if.slave    bus,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);
    localparam int              PH_W    = ptr_w(DECIM);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [IN_W:0]   RND     = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic [IN_W:0]   SAT_MAX = (IN_W+1)'((1 << OUT_W) - 1);

    logic [PH_W-1:0]  phase;
    logic             keep;
    logic [IN_W:0]    rounded;
    logic [IN_W:0]    shifted;
    logic [OUT_W-1:0] sat_data;
    logic             stage_valid;
    logic [OUT_W-1:0] stage_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OUT_W-1:0] fifo_dout;
    logic             pop;
    logic             drop;

    assign keep = bus.in_valid && (phase == '0);

    // Decimation phase: advances only on valid samples and wraps at DECIM-1.
    // NOTE: clocked state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
        end else if (bus.in_valid) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

    // Round half up in IN_W+1 bits, shift, then clamp to the OUT_W range.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        rounded  = '0;
        shifted  = '0;
        sat_data = '0;
        rounded  = {1'b0, bus.in_sample} + RND;
        shifted  = rounded >> SHIFT;
        sat_data = (shifted > SAT_MAX) ? '1 : shifted[OUT_W-1:0];
    end

    // Stage register: holds the kept, scaled sample for one cycle before the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else begin
            stage_valid <= keep;
            stage_data  <= sat_data;
        end
    end

    assign pop  = bus.out_valid && bus.out_ready;
    // A pop in the same cycle frees the slot, so full alone does not drop.
    assign drop = stage_valid && fifo_full && !pop;

    fir_out_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (stage_valid),
        .din   (stage_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.out_data  = fifo_dout;
    assign bus.out_valid = !fifo_empty;

    // Drop accounting: sticky overflow flag and a saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_decim_out.sv
// Bench for fir_decim_out: dut_a uses DECIM=4, dut_b uses DECIM=1. Expected
// outputs are queued as stimulus is driven and compared on every accepted
// output beat by a negedge monitor.
module tb_fir_decim_out;
    import fir_pkg::*;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int SHIFT = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fir_decim_out_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if_a ();
    fir_decim_out_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if_b ();

    logic       ovf_a, ovf_b;
    logic [7:0] drops_a, drops_b;

    fir_decim_out #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(4), .DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave), .overflow(ovf_a), .drop_count(drops_a)
    );

    fir_decim_out #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave), .overflow(ovf_b), .drop_count(drops_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned exp_a[$];
    int unsigned exp_b[$];

    typedef struct {
        logic [15:0] sample;
        logic [7:0]  expected;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference arithmetic: round half up, shift, clamp to 8-bit range.
    function automatic int unsigned model_out(input int unsigned x);
        int unsigned s;
        s = (x + (1 << (SHIFT - 1))) >> SHIFT;
        return (s > ((1 << OUT_W) - 1)) ? ((1 << OUT_W) - 1) : s;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        step();
        reset = 1'b1;
        exp_a.delete();
        exp_b.delete();
        step();
        reset = 1'b0;
    endtask

    task automatic drain_a;
        for (int i = 0; i < 50 && exp_a.size() != 0; i++) step();
        step();
        check("a_drained", exp_a.size(), 0);
        check("a_idle_valid", if_a.out_valid, 0);
    endtask

    task automatic drain_b;
        for (int i = 0; i < 50 && exp_b.size() != 0; i++) step();
        step();
        check("b_drained", exp_b.size(), 0);
        check("b_idle_valid", if_b.out_valid, 0);
    endtask

    // Scoreboard monitor: every accepted beat must match the head of the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (if_a.out_valid && if_a.out_ready) begin
                if (exp_a.size() == 0) check("a_spurious_beat", if_a.out_valid, 0);
                else check("a_data", if_a.out_data, exp_a.pop_front());
            end
            if (if_b.out_valid && if_b.out_ready) begin
                if (exp_b.size() == 0) check("b_spurious_beat", if_b.out_valid, 0);
                else check("b_data", if_b.out_data, exp_b.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        logic [15:0] gap_s[8];

        if_a.in_valid = 1'b0; if_a.in_sample = '0; if_a.out_ready = 1'b1;
        if_b.in_valid = 1'b0; if_b.in_sample = '0; if_b.out_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst_a_valid", if_a.out_valid, 0);
        check("rst_a_data", if_a.out_data, 0);
        check("rst_a_ovf", ovf_a, 0);
        check("rst_a_drops", drops_a, 0);
        check("rst_b_valid", if_b.out_valid, 0);
        check("rst_b_data", if_b.out_data, 0);
        check("rst_b_ovf", ovf_b, 0);
        check("rst_b_drops", drops_b, 0);

        // 1: decimation by 4 with latency check on the first kept sample
        for (int i = 0; i < 16; i++) begin
            if_a.in_valid  = 1'b1;
            if_a.in_sample = 16'(16 * i);
            if (i % 4 == 0) exp_a.push_back(model_out(16 * i));
            @(negedge clk);
            if (i < 3) check("t1_latency_valid", if_a.out_valid, (i == 2) ? 1 : 0);
            step();
        end
        if_a.in_valid = 1'b0;
        drain_a();

        // 2: rounding and saturation table, DECIM=1
        vecs = '{
            '{16'h0007, 8'd0},   '{16'h0008, 8'd1},   '{16'h0FF7, 8'd255},
            '{16'h1000, 8'd255}, '{16'hFFFF, 8'd255}, '{16'h0017, 8'd1},
            '{16'h0018, 8'd2}
        };
        for (int i = 0; i < 7; i++) begin
            if_b.in_valid  = 1'b1;
            if_b.in_sample = vecs[i].sample;
            exp_b.push_back(vecs[i].expected);
            step();
        end
        if_b.in_valid = 1'b0;
        drain_b();
        check("t2_ovf", ovf_b, 0);

        // 3: backpressure -- 6 samples into a 4-deep FIFO
        do_reset();
        if_b.out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if_b.in_valid  = 1'b1;
            if_b.in_sample = 16'(k << 4);
            if (k <= 4) exp_b.push_back(model_out(k << 4));
            step();
        end
        if_b.in_valid = 1'b0;
        step();
        step();
        check("t3_ovf", ovf_b, 1);
        check("t3_drops", drops_b, 2);
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", if_b.out_valid, 1);
            check("t3_hold_data", if_b.out_data, 1);
            step();
        end
        if_b.out_ready = 1'b1;
        drain_b();

        // 4: full FIFO with simultaneous push and pop
        do_reset();
        if_b.out_ready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 6) if_b.out_ready = 1'b1;
            if_b.in_valid  = 1'b1;
            if_b.in_sample = 16'(k * 16'h0123);
            exp_b.push_back(model_out(k * 16'h0123));
            step();
        end
        if_b.in_valid = 1'b0;
        drain_b();
        check("t4_drops", drops_b, 0);
        check("t4_ovf", ovf_b, 0);

        // 5: reset mid-run flushes queued samples and clears drop state
        do_reset();
        if_a.out_ready = 1'b0;
        if_b.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if_a.in_valid  = 1'b1;
            if_a.in_sample = 16'(i * 100 + 50);
            if (i % 4 == 0) exp_a.push_back(model_out(i * 100 + 50));
            if (i < 6) begin
                if_b.in_valid  = 1'b1;
                if_b.in_sample = 16'(i * 100 + 50);
                if (i < 4) exp_b.push_back(model_out(i * 100 + 50));
            end else begin
                if_b.in_valid = 1'b0;
            end
            step();
        end
        if_a.in_valid = 1'b0;
        if_b.in_valid = 1'b0;
        step();
        step();
        check("t5_pre_a_valid", if_a.out_valid, 1);
        check("t5_pre_b_ovf", ovf_b, 1);
        reset = 1'b1;
        exp_a.delete();
        exp_b.delete();
        step();
        reset = 1'b0;
        check("t5_a_valid", if_a.out_valid, 0);
        check("t5_b_valid", if_b.out_valid, 0);
        check("t5_b_ovf", ovf_b, 0);
        check("t5_b_drops", drops_b, 0);
        if_a.out_ready = 1'b1;
        if_b.out_ready = 1'b1;
        if_a.in_valid  = 1'b1;
        if_a.in_sample = 16'h0AB0;
        exp_a.push_back(model_out(16'h0AB0));
        step();
        if_a.in_valid = 1'b0;
        check("t5_lat1_valid", if_a.out_valid, 0);
        step();
        check("t5_lat2_valid", if_a.out_valid, 1);
        check("t5_lat2_data", if_a.out_data, model_out(16'h0AB0));
        drain_a();

        // 6: gapped in_valid, phase holds on idle cycles
        do_reset();
        gap_s = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                  16'h5555, 16'h6666, 16'h7777, 16'h0888};
        for (int i = 0; i < 8; i++) begin
            if_a.in_valid  = 1'b1;
            if_a.in_sample = gap_s[i];
            if (i == 0 || i == 4) exp_a.push_back(model_out(gap_s[i]));
            step();
            if_a.in_valid = 1'b0;
            step();
        end
        drain_a();

        // 7: drop counter saturates at 255
        do_reset();
        if_b.out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if_b.in_valid  = 1'b1;
            if_b.in_sample = 16'(i * 7);
            if (i < 4) exp_b.push_back(model_out(i * 7));
            step();
        end
        if_b.in_valid = 1'b0;
        step();
        step();
        check("t7_drops_sat", drops_b, 255);
        check("t7_ovf", ovf_b, 1);
        if_b.out_ready = 1'b1;
        drain_b();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
